// File: rtl/qpsk_pkg.sv
// Shared QPSK constants: symbol length, table amplitude and the sine/cosine
// reference tables used by both the modulator and the demodulator.
package qpsk_pkg;

  localparam int SYM_LEN = 100;
  localparam int TBL_AMP = 1000;
  localparam int TBL_W   = 11;

  typedef logic [6:0] phase_t;
  typedef logic signed [TBL_W-1:0] tbl_t;

  localparam phase_t FIRST_PHASE = 7'd0;
  localparam phase_t LAST_PHASE  = 7'd99;

  // round(TBL_AMP * sin(2*pi*p/SYM_LEN))
  localparam tbl_t SIN_TBL [SYM_LEN] = '{
      11'sd0,     11'sd63,    11'sd125,   11'sd187,   11'sd249,
      11'sd309,   11'sd368,   11'sd426,   11'sd482,   11'sd536,
      11'sd588,   11'sd637,   11'sd685,   11'sd729,   11'sd771,
      11'sd809,   11'sd844,   11'sd876,   11'sd905,   11'sd930,
      11'sd951,   11'sd969,   11'sd982,   11'sd992,   11'sd998,
      11'sd1000,  11'sd998,   11'sd992,   11'sd982,   11'sd969,
      11'sd951,   11'sd930,   11'sd905,   11'sd876,   11'sd844,
      11'sd809,   11'sd771,   11'sd729,   11'sd685,   11'sd637,
      11'sd588,   11'sd536,   11'sd482,   11'sd426,   11'sd368,
      11'sd309,   11'sd249,   11'sd187,   11'sd125,   11'sd63,
      11'sd0,    -11'sd63,   -11'sd125,  -11'sd187,  -11'sd249,
     -11'sd309,  -11'sd368,  -11'sd426,  -11'sd482,  -11'sd536,
     -11'sd588,  -11'sd637,  -11'sd685,  -11'sd729,  -11'sd771,
     -11'sd809,  -11'sd844,  -11'sd876,  -11'sd905,  -11'sd930,
     -11'sd951,  -11'sd969,  -11'sd982,  -11'sd992,  -11'sd998,
     -11'sd1000, -11'sd998,  -11'sd992,  -11'sd982,  -11'sd969,
     -11'sd951,  -11'sd930,  -11'sd905,  -11'sd876,  -11'sd844,
     -11'sd809,  -11'sd771,  -11'sd729,  -11'sd685,  -11'sd637,
     -11'sd588,  -11'sd536,  -11'sd482,  -11'sd426,  -11'sd368,
     -11'sd309,  -11'sd249,  -11'sd187,  -11'sd125,  -11'sd63
  };

  // round(TBL_AMP * cos(2*pi*p/SYM_LEN)), i.e. the sine table advanced a quarter period
  localparam tbl_t COS_TBL [SYM_LEN] = '{
      11'sd1000,  11'sd998,   11'sd992,   11'sd982,   11'sd969,
      11'sd951,   11'sd930,   11'sd905,   11'sd876,   11'sd844,
      11'sd809,   11'sd771,   11'sd729,   11'sd685,   11'sd637,
      11'sd588,   11'sd536,   11'sd482,   11'sd426,   11'sd368,
      11'sd309,   11'sd249,   11'sd187,   11'sd125,   11'sd63,
      11'sd0,    -11'sd63,   -11'sd125,  -11'sd187,  -11'sd249,
     -11'sd309,  -11'sd368,  -11'sd426,  -11'sd482,  -11'sd536,
     -11'sd588,  -11'sd637,  -11'sd685,  -11'sd729,  -11'sd771,
     -11'sd809,  -11'sd844,  -11'sd876,  -11'sd905,  -11'sd930,
     -11'sd951,  -11'sd969,  -11'sd982,  -11'sd992,  -11'sd998,
     -11'sd1000, -11'sd998,  -11'sd992,  -11'sd982,  -11'sd969,
     -11'sd951,  -11'sd930,  -11'sd905,  -11'sd876,  -11'sd844,
     -11'sd809,  -11'sd771,  -11'sd729,  -11'sd685,  -11'sd637,
     -11'sd588,  -11'sd536,  -11'sd482,  -11'sd426,  -11'sd368,
     -11'sd309,  -11'sd249,  -11'sd187,  -11'sd125,  -11'sd63,
      11'sd0,     11'sd63,    11'sd125,   11'sd187,   11'sd249,
      11'sd309,   11'sd368,   11'sd426,   11'sd482,   11'sd536,
      11'sd588,   11'sd637,   11'sd685,   11'sd729,   11'sd771,
      11'sd809,   11'sd844,   11'sd876,   11'sd905,   11'sd930,
      11'sd951,   11'sd969,   11'sd982,   11'sd992,   11'sd998
  };

  function automatic phase_t next_phase(input phase_t p);
    return (p == LAST_PHASE) ? FIRST_PHASE : p + 7'd1;
  endfunction

endpackage

// File: rtl/qpsk_ref_lut.sv
// Combinational phase -> (sin, cos) reference lookup.
module qpsk_ref_lut
  import qpsk_pkg::*;
(
  input  phase_t phase,
  output tbl_t   sin_val,
  output tbl_t   cos_val
);

  // Phases beyond the symbol length never occur; they read as zero.
  always_comb begin
    sin_val = '0;
    cos_val = '0;
    if (phase <= LAST_PHASE) begin
      sin_val = SIN_TBL[phase];
      cos_val = COS_TBL[phase];
    end
  end

endmodule

// File: rtl/qpsk_demodulator.sv
// Coherent QPSK demodulator: correlates each 100-sample symbol against the
// reference sine/cosine and emits hard E/O decisions plus the soft sums.
module qpsk_demodulator
  import qpsk_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  input  logic                     sync,
  output logic                     E,
  output logic                     O,
  output logic                     sym_valid,
  output logic signed [ACC_W-1:0]  corr_i,
  output logic signed [ACC_W-1:0]  corr_q
);

  localparam int PROD_W = 2 * DATA_W;

  phase_t                    phase_cnt;
  phase_t                    cur_phase;

  logic                      s1_valid;
  logic                      s1_first;
  logic                      s1_last;
  logic signed [DATA_W-1:0]  s1_data;
  phase_t                    s1_phase;

  tbl_t                      sin_val;
  tbl_t                      cos_val;
  logic signed [PROD_W-1:0]  prod_s_next;
  logic signed [PROD_W-1:0]  prod_c_next;

  logic                      s2_valid;
  logic                      s2_first;
  logic                      s2_last;
  logic signed [PROD_W-1:0]  s2_prod_s;
  logic signed [PROD_W-1:0]  s2_prod_c;

  logic signed [ACC_W-1:0]   acc_s;
  logic signed [ACC_W-1:0]   acc_c;
  logic signed [ACC_W-1:0]   prod_s_ext;
  logic signed [ACC_W-1:0]   prod_c_ext;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   sum_c;

  // sync restarts the symbol on the very sample it qualifies.
  assign cur_phase = sync ? FIRST_PHASE : phase_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      phase_cnt <= FIRST_PHASE;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_data   <= '0;
      s1_phase  <= FIRST_PHASE;
    end else begin
      s1_valid <= data_valid;
      if (data_valid) begin
        s1_data   <= data_in;
        s1_phase  <= cur_phase;
        s1_first  <= (cur_phase == FIRST_PHASE);
        s1_last   <= (cur_phase == LAST_PHASE);
        phase_cnt <= next_phase(cur_phase);
      end
    end
  end

  qpsk_ref_lut u_lut (
    .phase   (s1_phase),
    .sin_val (sin_val),
    .cos_val (cos_val)
  );

  assign prod_s_next = PROD_W'(s1_data) * PROD_W'(sin_val);
  assign prod_c_next = PROD_W'(s1_data) * PROD_W'(cos_val);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_prod_s <= '0;
      s2_prod_c <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_prod_s <= prod_s_next;
      s2_prod_c <= prod_c_next;
    end
  end

  assign prod_s_ext = ACC_W'(s2_prod_s);
  assign prod_c_ext = ACC_W'(s2_prod_c);
  assign sum_s      = acc_s + prod_s_ext;
  assign sum_c      = acc_c + prod_c_ext;

  // Phase 0 reloads, phase 99 decides and clears, everything else accumulates.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_s     <= '0;
      acc_c     <= '0;
      E         <= 1'b0;
      O         <= 1'b0;
      sym_valid <= 1'b0;
      corr_i    <= '0;
      corr_q    <= '0;
    end else begin
      sym_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_first) begin
          acc_s <= prod_s_ext;
          acc_c <= prod_c_ext;
        end else if (s2_last) begin
          acc_s     <= '0;
          acc_c     <= '0;
          corr_i    <= sum_s;
          corr_q    <= sum_c;
          E         <= sum_s[ACC_W-1];
          O         <= !sum_c[ACC_W-1] && (sum_c != '0);
          sym_valid <= 1'b1;
        end else begin
          acc_s <= sum_s;
          acc_c <= sum_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Randomised scoreboard bench for qpsk_demodulator against a symbol-level
// correlation model built from freshly computed sine/cosine tables.
module tb_qpsk_demodulator;

  localparam int  DATA_W = 12;
  localparam int  ACC_W  = 32;
  localparam int  PER    = 10;
  localparam real PI     = 3.14159265358979323846;

  logic                     Clk = 1'b0;
  logic                     Rst;
  logic signed [DATA_W-1:0] data_in;
  logic                     data_valid;
  logic                     sync;
  logic                     E;
  logic                     O;
  logic                     sym_valid;
  logic signed [ACC_W-1:0]  corr_i;
  logic signed [ACC_W-1:0]  corr_q;

  int tests_run    = 0;
  int tests_failed = 0;

  int sin_ref [100];
  int cos_ref [100];
  int cur [$];

  typedef struct {
    bit     e;
    bit     o;
    longint ci;
    longint cq;
    time    t;
  } exp_t;

  exp_t sb [$];

  qpsk_demodulator #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .sync       (sync),
    .E          (E),
    .O          (O),
    .sym_valid  (sym_valid),
    .corr_i     (corr_i),
    .corr_q     (corr_q)
  );

  always #(PER/2) Clk = ~Clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A symbol completes once 100 samples have been collected since the last
  // sync/reset/decision; its pulse appears two edges after the last one.
  function automatic void model_accept(input int data, input bit syn, input time tk);
    longint fs;
    longint fc;
    exp_t   x;
    if (syn) cur.delete();
    cur.push_back(data);
    if (cur.size() == 100) begin
      fs = 0;
      fc = 0;
      for (int p = 0; p < 100; p++) begin
        fs += longint'(cur[p]) * longint'(sin_ref[p]);
        fc += longint'(cur[p]) * longint'(cos_ref[p]);
      end
      x.e  = (fs < 0);
      x.o  = (fc > 0);
      x.ci = fs;
      x.cq = fc;
      x.t  = tk + time'(2 * PER + PER / 2);
      sb.push_back(x);
      cur.delete();
    end
  endfunction

  task automatic applyStimulus(input int data, input bit valid, input bit syn);
    data_in    = DATA_W'(data);
    data_valid = valid;
    sync       = syn;
    @(posedge Clk);
    if (valid) model_accept(data, syn, $time);
    #1;
  endtask

  function automatic int sym_sample(input bit e, input bit o, input int p, input int noise);
    int v;
    v = (o ? cos_ref[p] : -cos_ref[p]) - (e ? sin_ref[p] : -sin_ref[p]);
    if (noise > 0) v += int'($urandom_range(0, 2 * noise)) - noise;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v;
  endfunction

  // gap_mode: 0 contiguous, 1 idle cycle before every sample, 2 random idles
  task automatic send_symbol(input bit e, input bit o, input int gap_mode,
                             input int noise, input bit sync_first, input int count);
    for (int p = 0; p < count; p++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
        applyStimulus(int'($urandom_range(0, 4095)) - 2048, 1'b0, 1'($urandom_range(0, 1)));
      applyStimulus(sym_sample(e, o, p, noise), 1'b1, sync_first && (p == 0));
    end
  endtask

  task automatic do_reset();
    Rst        = 1'b1;
    data_valid = 1'b0;
    sync       = 1'b0;
    @(posedge Clk);
    cur.delete();
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].t > $time) sb.delete(i);
    #1;
    Rst = 1'b0;
    checkOutput("rst_E",         longint'(E),         longint'(0));
    checkOutput("rst_O",         longint'(O),         longint'(0));
    checkOutput("rst_sym_valid", longint'(sym_valid), longint'(0));
    checkOutput("rst_corr_i",    longint'(corr_i),    longint'(0));
    checkOutput("rst_corr_q",    longint'(corr_q),    longint'(0));
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin : monitor
    exp_t x;
    if (sb.size() > 0 && sb[0].t < $time) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL missing_pulse: no sym_valid pulse by expected time %0t", sb[0].t);
      void'(sb.pop_front());
    end
    if (sym_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_pulse: pulse at time %0t, expected none", $time);
      end else begin
        x = sb.pop_front();
        checkOutput("pulse_time", longint'($time),  longint'(x.t));
        checkOutput("E",          longint'(E),      longint'(x.e));
        checkOutput("O",          longint'(O),      longint'(x.o));
        checkOutput("corr_i",     longint'(corr_i), x.ci);
        checkOutput("corr_q",     longint'(corr_q), x.cq);
      end
    end
  end

  initial begin
    for (int p = 0; p < 100; p++) begin
      sin_ref[p] = $rtoi($floor(1000.0 * $sin(2.0 * PI * real'(p) / 100.0) + 0.5));
      cos_ref[p] = $rtoi($floor(1000.0 * $cos(2.0 * PI * real'(p) / 100.0) + 0.5));
    end
    Rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    sync       = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    do_reset();

    $display("[TB] single clean symbol E=1 O=1");
    send_symbol(1'b1, 1'b1, 0, 0, 1'b0, 100);

    $display("[TB] four contiguous symbols 11,10,01,00");
    for (int i = 0; i < 4; i++)
      send_symbol(1'(i < 2), 1'(i % 2 == 0), 0, 0, 1'(i % 2), 100);

    $display("[TB] data_valid toggling");
    send_symbol(1'b1, 1'b1, 1, 0, 1'b1, 100);

    $display("[TB] sync at phase 40 then symbol E=0 O=1");
    send_symbol(1'b1, 1'b0, 0, 0, 1'b1, 40);
    send_symbol(1'b0, 1'b1, 0, 0, 1'b1, 100);

    $display("[TB] reset at phase 60 then full symbol");
    send_symbol(1'b0, 1'b0, 0, 0, 1'b1, 60);
    do_reset();
    send_symbol(1'b1, 1'b0, 0, 0, 1'b0, 100);

    $display("[TB] all-zero symbol");
    for (int p = 0; p < 100; p++) applyStimulus(0, 1'b1, p == 0);

    $display("[TB] sync on would-be phase 99");
    send_symbol(1'b1, 1'b0, 0, 0, 1'b1, 99);
    send_symbol(1'b0, 1'b0, 0, 0, 1'b1, 100);

    $display("[TB] full-range random samples");
    for (int p = 0; p < 100; p++)
      applyStimulus(int'($urandom_range(0, 4095)) - 2048, 1'b1, p == 0);

    $display("[TB] randomised symbols with gaps, noise and aborts");
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 4) == 0)
        send_symbol(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 200, 1'b1,
                    int'($urandom_range(1, 99)));
      send_symbol(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 200,
                  1'b1, 100);
    end

    data_valid = 1'b0;
    sync       = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    checkOutput("scoreboard_drained", longint'(sb.size()), longint'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
